// File: rtl/fsk_tx_sequencer.sv
// Byte-to-symbol transmit sequencer for the FSK modulator: async framing
// (start, 8 data LSB first, optional parity, stop bits) with each symbol held SYM_CYCLES clocks.
module fsk_tx_sequencer #(
  parameter int SYM_CYCLES = 32,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       dado,
  output logic       sym_strobe,
  output logic       busy,
  output logic       frame_done
);

  localparam int            CW        = (SYM_CYCLES > 1) ? $clog2(SYM_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(SYM_CYCLES - 1);
  localparam logic          STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic          stop_idx_q, stop_idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          parity_q, parity_d;
  logic          dado_q, dado_d;
  logic          sym_strobe_q, sym_strobe_d;
  logic          busy_q, busy_d;
  logic          frame_done_q, frame_done_d;

  logic sym_end;
  logic last_stop;
  logic handshake;

  assign sym_end   = (cnt_q == CNT_MAX);
  assign last_stop = (state_q == STOP) && sym_end && (stop_idx_q == STOP_LAST);
  assign tx_ready  = !reset && ((state_q == IDLE) || last_stop);
  assign handshake = tx_valid && tx_ready;

  // Registered outputs are derived from the next-state values so they line up with the state they describe.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    shreg_d    = shreg_q;
    parity_d   = parity_q;

    if (state_q != IDLE) begin
      cnt_d = sym_end ? '0 : cnt_q + CW'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (handshake) begin
          state_d    = START;
          cnt_d      = '0;
          bit_idx_d  = 3'd0;
          stop_idx_d = 1'b0;
          shreg_d    = tx_data;
          parity_d   = (^tx_data) ^ (PARITY_ODD != 0);
        end
      end
      START: begin
        if (sym_end) begin
          state_d   = DATA;
          bit_idx_d = 3'd0;
        end
      end
      DATA: begin
        if (sym_end) begin
          shreg_d = {1'b0, shreg_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d    = (PARITY_EN != 0) ? PARITY : STOP;
            stop_idx_d = 1'b0;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (sym_end) begin
          state_d    = STOP;
          stop_idx_d = 1'b0;
        end
      end
      STOP: begin
        if (sym_end) begin
          if (stop_idx_q == STOP_LAST) begin
            if (handshake) begin
              state_d    = START;
              bit_idx_d  = 3'd0;
              stop_idx_d = 1'b0;
              shreg_d    = tx_data;
              parity_d   = (^tx_data) ^ (PARITY_ODD != 0);
            end else begin
              state_d = IDLE;
            end
          end else begin
            stop_idx_d = stop_idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    unique case (state_d)
      START:   dado_d = 1'b0;
      DATA:    dado_d = shreg_d[0];
      PARITY:  dado_d = parity_d;
      default: dado_d = 1'b1;
    endcase
    busy_d       = (state_d != IDLE);
    sym_strobe_d = (state_d != IDLE) && (cnt_d == '0);
    frame_done_d = (state_d == STOP) && (cnt_d == CNT_MAX) && (stop_idx_d == STOP_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= 3'd0;
      stop_idx_q   <= 1'b0;
      shreg_q      <= 8'h00;
      parity_q     <= 1'b0;
      dado_q       <= 1'b1;
      sym_strobe_q <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      stop_idx_q   <= stop_idx_d;
      shreg_q      <= shreg_d;
      parity_q     <= parity_d;
      dado_q       <= dado_d;
      sym_strobe_q <= sym_strobe_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign dado       = dado_q;
  assign sym_strobe = sym_strobe_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_fsk_tx_sequencer.sv
// Directed bench for fsk_tx_sequencer: default framing plus even/odd parity instances.
module tb_fsk_tx_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic [2:0] tx_valid_v = 3'b000;
  logic [2:0] tx_ready_w, dado_w, strobe_w, busy_w, done_w;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fsk_tx_sequencer dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid_v[0]),
    .tx_ready(tx_ready_w[0]), .dado(dado_w[0]), .sym_strobe(strobe_w[0]),
    .busy(busy_w[0]), .frame_done(done_w[0]));

  fsk_tx_sequencer #(.SYM_CYCLES(32), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut_pe (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid_v[1]),
    .tx_ready(tx_ready_w[1]), .dado(dado_w[1]), .sym_strobe(strobe_w[1]),
    .busy(busy_w[1]), .frame_done(done_w[1]));

  fsk_tx_sequencer #(.SYM_CYCLES(32), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut_po (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid_v[2]),
    .tx_ready(tx_ready_w[2]), .dado(dado_w[2]), .sym_strobe(strobe_w[2]),
    .busy(busy_w[2]), .frame_done(done_w[2]));

  // Returns right after the handshake edge T, so the next negedge observes cycle T+1.
  task automatic handshake(input int which, input logic [7:0] d);
    @(negedge clk);
    tx_data = d;
    tx_valid_v[which] = 1'b1;
    checks++;
    if (tx_ready_w[which] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL handshake_ready dut%0d: tx_ready=%b expected 1", which, tx_ready_w[which]);
    end
    @(posedge clk);
    #1;
    tx_valid_v[which] = 1'b0;
  endtask

  task automatic check_frame(input int which, input string name, input logic [11:0] exp_syms, input int nsym);
    int total = nsym * 32;
    int s, j;
    int hold_err = 0, strobe_bad = 0, strobes = 0, busy_err = 0;
    int done_cnt = 0, done_at = -1, ready_cnt = 0, ready_at = -1;
    logic cur = 1'b1;
    for (int k = 1; k <= total; k++) begin
      @(negedge clk);
      s = (k - 1) / 32;
      j = (k - 1) % 32;
      if (j == 0) begin
        checks++;
        if (dado_w[which] !== exp_syms[s]) begin
          errors++;
          $display("[TB] FAIL %s sym%0d: dado=%b expected %b", name, s, dado_w[which], exp_syms[s]);
        end
        cur = exp_syms[s];
      end else if (dado_w[which] !== cur) begin
        hold_err++;
      end
      if (strobe_w[which] !== (j == 0)) strobe_bad++;
      if (strobe_w[which] === 1'b1) strobes++;
      if (busy_w[which] !== 1'b1) busy_err++;
      if (done_w[which] === 1'b1) begin done_cnt++; done_at = k; end
      if (tx_ready_w[which] === 1'b1) begin ready_cnt++; ready_at = k; end
    end
    checks++;
    if (hold_err != 0) begin
      errors++;
      $display("[TB] FAIL %s_hold: %0d mid-symbol dado changes, expected 0", name, hold_err);
    end
    checks++;
    if (strobes != nsym || strobe_bad != 0) begin
      errors++;
      $display("[TB] FAIL %s_strobe: %0d pulses (%0d misplaced), expected %0d", name, strobes, strobe_bad, nsym);
    end
    checks++;
    if (busy_err != 0) begin
      errors++;
      $display("[TB] FAIL %s_busy: busy low on %0d frame cycles, expected 0", name, busy_err);
    end
    checks++;
    if (done_cnt != 1 || done_at != total) begin
      errors++;
      $display("[TB] FAIL %s_done: %0d pulses last at cycle %0d, expected 1 at %0d", name, done_cnt, done_at, total);
    end
    checks++;
    if (ready_cnt != 1 || ready_at != total) begin
      errors++;
      $display("[TB] FAIL %s_ready: high %0d cycles last at %0d, expected 1 at %0d", name, ready_cnt, ready_at, total);
    end
  endtask

  task automatic check_idle(input int which, input string name);
    @(negedge clk);
    checks++;
    if ({dado_w[which], busy_w[which], strobe_w[which], done_w[which], tx_ready_w[which]} !== 5'b10001) begin
      errors++;
      $display("[TB] FAIL %s: dado/busy/strobe/done/ready=%b expected 10001", name,
               {dado_w[which], busy_w[which], strobe_w[which], done_w[which], tx_ready_w[which]});
    end
  endtask

  task automatic test_reset();
    int viol = 0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({dado_w[0], busy_w[0], strobe_w[0], done_w[0], tx_ready_w[0]} !== 5'b10000) begin
      errors++;
      $display("[TB] FAIL reset_hold: dado/busy/strobe/done/ready=%b expected 10000",
               {dado_w[0], busy_w[0], strobe_w[0], done_w[0], tx_ready_w[0]});
    end
    reset = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      for (int w = 0; w < 3; w++)
        if ({dado_w[w], busy_w[w], strobe_w[w], done_w[w], tx_ready_w[w]} !== 5'b10001) viol++;
    end
    checks++;
    if (viol != 0) begin
      errors++;
      $display("[TB] FAIL reset_idle: %0d bad idle samples, expected 0", viol);
    end
  endtask

  task automatic test_single_byte();
    handshake(0, 8'hA5);
    check_frame(0, "single_a5", 12'b00_1101001010, 10);
    check_idle(0, "single_a5_after");
  endtask

  task automatic test_parity();
    handshake(1, 8'h07);
    check_frame(1, "parity_even", 12'b0_11000001110, 11);
    check_idle(1, "parity_even_after");
    handshake(2, 8'h07);
    check_frame(2, "parity_odd", 12'b0_10000001110, 11);
    check_idle(2, "parity_odd_after");
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    tx_data = 8'h00;
    tx_valid_v[0] = 1'b1;
    @(posedge clk);
    #1;
    tx_data = 8'hFF;
    check_frame(0, "b2b_first", 12'b00_1000000000, 10);
    @(posedge clk);
    #1;
    tx_valid_v[0] = 1'b0;
    check_frame(0, "b2b_second", 12'b00_1111111110, 10);
    check_idle(0, "b2b_after");
  endtask

  task automatic test_mid_frame_reset();
    int stray = 0;
    handshake(0, 8'h55);
    repeat (140) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({dado_w[0], busy_w[0], strobe_w[0], done_w[0], tx_ready_w[0]} !== 5'b10000) begin
      errors++;
      $display("[TB] FAIL midreset_abort: dado/busy/strobe/done/ready=%b expected 10000",
               {dado_w[0], busy_w[0], strobe_w[0], done_w[0], tx_ready_w[0]});
    end
    reset = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done_w[0] !== 1'b0 || busy_w[0] !== 1'b0 || dado_w[0] !== 1'b1) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("[TB] FAIL midreset_quiet: %0d non-idle samples after abort, expected 0", stray);
    end
    handshake(0, 8'h3C);
    check_frame(0, "midreset_3c", 12'b00_1001111000, 10);
    check_idle(0, "midreset_3c_after");
  endtask

  task automatic test_data_stability();
    handshake(0, 8'h81);
    fork
      check_frame(0, "stable_81", 12'b00_1100000010, 10);
      begin
        for (int k = 0; k < 320; k++) begin
          @(posedge clk);
          #1;
          tx_data = 8'($urandom);
        end
      end
    join
    check_idle(0, "stable_81_after");
  endtask

  task automatic test_reset_handshake();
    int stray = 0;
    @(negedge clk);
    reset = 1'b1;
    tx_data = 8'h5A;
    tx_valid_v[0] = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tx_valid_v[0] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (busy_w[0] !== 1'b0 || strobe_w[0] !== 1'b0 || dado_w[0] !== 1'b1) stray++;
      @(negedge clk);
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("[TB] FAIL reset_vs_handshake: %0d samples show a started frame, expected 0", stray);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_parity();
    test_back_to_back();
    test_mid_frame_reset();
    test_data_stability();
    test_reset_handshake();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fsk_tx_sequencer.md
Name: fsk_tx_sequencer

Overview:
Byte-level transmit controller for the FSK modulator (1000 Hz / 1500 Hz, 32-sample LUT).
- Accepts bytes over a valid/ready handshake and serialises each into an asynchronous frame: start bit, 8 data bits LSB first, optional parity, stop bit(s).
- Drives the modulator's 1-bit `dado` input, holding each symbol for a fixed number of clocks.
- Outputs mark (1) while idle.

Parameters:
- SYM_CYCLES, 32: clocks per symbol. Must be ≥ 2.
- PARITY_EN, 0: 1 inserts a parity symbol after the data bits.
- PARITY_ODD, 0: 0 = even parity, 1 = odd parity. Ignored when PARITY_EN=0.
- STOP_BITS, 1: number of stop symbols (1 or 2), each of value 1.

Ports:
- clk, input, 1: system clock; all logic on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- tx_data, input, 8: byte to transmit; sampled on handshake.
- tx_valid, input, 1: requester has a byte.
- tx_ready, output, 1: sequencer can accept a byte this cycle.
- dado, output, 1: symbol bit to the modulator (0 = 1000 Hz, 1 = 1500 Hz).
- sym_strobe, output, 1: one-cycle pulse on the first cycle of every frame symbol.
- busy, output, 1: high from the first start-bit cycle through the last stop cycle.
- frame_done, output, 1: one-cycle pulse on the last cycle of the last stop symbol.

Behaviour:
- Reset (reset=1 at a clock edge):
  - State goes to IDLE; all counters clear; the shift register clears.
  - Outputs next cycle: dado=1, sym_strobe=0, busy=0, frame_done=0.
  - tx_ready=0 while reset is high, then 1 in the first IDLE cycle after reset deasserts.
- States: IDLE, START, DATA, PARITY, STOP.
- Handshake:
  - A transfer occurs at an edge where tx_valid=1 and tx_ready=1. tx_data is latched into an 8-bit shift register.
  - tx_ready=1 in IDLE, and also in the final cycle of the final stop symbol (back-to-back support). It is 0 at all other times.
  - tx_valid without tx_ready has no effect, and the data is not sampled.
- Symbol timing:
  - A symbol counter counts 0..SYM_CYCLES-1, width clog2(SYM_CYCLES).
  - A symbol ends when the counter reaches SYM_CYCLES-1; the counter then wraps to 0.
- Transitions:
  - IDLE -> START on handshake. The next cycle has dado=0, sym_strobe=1, busy=1.
  - START -> DATA at symbol end. The bit index is 0..7; dado = shift register bit 0; the register shifts right at each data symbol end.
  - DATA -> PARITY at the end of bit 7 if PARITY_EN=1; otherwise DATA -> STOP.
  - PARITY symbol value = XOR of the 8 latched bits, XOR PARITY_ODD. The parity is computed from the latched byte, not the shifted register.
  - STOP: dado=1 for STOP_BITS symbols.
  - In the last cycle of the last stop symbol, frame_done=1 and tx_ready=1.
    - If a handshake occurs there, go to START: no idle gap, and the next cycle is the new start bit with sym_strobe=1.
    - Otherwise go to IDLE: dado stays 1 and busy=0 next cycle.
- Frame length: (1 + 8 + PARITY_EN + STOP_BITS) × SYM_CYCLES clocks.
  - For a handshake at edge T, data bit i occupies cycles starting at T+1+(1+i)·SYM_CYCLES.
- Output registration:
  - dado, sym_strobe, busy and frame_done are registered.
  - tx_ready is combinational from state and counters, with no path from tx_valid.
- Boundary conditions:
  - Reset mid-frame aborts immediately: dado=1 the cycle after the reset edge, the byte is discarded, and frame_done is not pulsed.
  - tx_data changing after the handshake does not affect the frame in flight.
  - Reset and handshake at the same edge: reset wins and the byte is dropped.
- dado never glitches mid-symbol; it changes only on cycles where sym_strobe=1, or on exit to IDLE/reset.

Test Plan:
- Reset then idle, with reset held for 3 cycles then released and tx_valid=0 for 100 cycles -> dado=1, busy=0, tx_ready=1 and sym_strobe=0 throughout.
- Single byte, defaults (SYM_CYCLES=32), tx_data=0xA5 -> 320-cycle frame, each symbol held exactly 32 cycles:
  - dado symbol sequence is 0,1,0,1,0,0,1,0,1,1.
  - 10 sym_strobe pulses.
  - frame_done on cycle T+320, busy low at T+321.
- Parity, with PARITY_EN=1, PARITY_ODD=0, tx_data=0x07 -> the parity symbol is 1. With PARITY_ODD=1 it is 0. Frame length is 352 cycles.
- Back-to-back, with tx_valid held high for 0x00 then 0xFF -> the second start bit immediately follows the first stop bit (no idle cycle), tx_ready is high for exactly 1 cycle between frames, and the dado stream is 0,0×8,1,0,1×8,1.
- Mid-frame reset, with reset pulsed during data bit 3 of 0x55 -> dado=1 the next cycle, no frame_done, and a new byte 0x3C afterwards transmits correctly from the start bit.
- Data stability, with tx_data changed every cycle after the handshake of 0x81 -> the transmitted bits still match 0x81, i.e. 1,0,0,0,0,0,0,1.
